// File: rtl/sevenseg_scan_ctrl.sv
// Refresh scheduler for an 8-digit multiplexed seven-segment display.
// Holds the digit register file and time-shares the cathode bus with a blanking gap per slot.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [2:0]            sel,
  input  logic [3:0]            num,
  input  logic                  mask_wr,
  input  logic [NUM_DIGITS-1:0] en_mask,
  output logic [NUM_DIGITS-1:0] ANODE,
  output logic [6:0]            CATHODE,
  output logic                  frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntShow = CntW'(BLANK_CYCLES);
  localparam logic [2:0] IdxLast = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AnodeOne = NUM_DIGITS'(1);
  localparam logic [6:0] SegOff = 7'h7F;

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [2:0]                     idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     digit_q, digit_d;
  logic [NUM_DIGITS-1:0]          mask_q, mask_d;
  logic [NUM_DIGITS-1:0]          anode_q, anode_d;
  logic [6:0]                     cathode_q, cathode_d;
  logic                           tick_q, tick_d;
  logic                           slot_end;

  // Active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign slot_end = (cnt_q == CntLast);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 3'd1 : idx_q;
  end

  // State tracks cnt_d so state_q is SHOW exactly when cnt_q >= BLANK_CYCLES.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: if (!slot_end && cnt_d == CntShow) state_d = StShow;
      StShow:  if (slot_end) state_d = StBlank;
      default: state_d = StBlank;
    endcase
  end

  always_comb begin
    digit_d = digit_q;
    if (write) digit_d[sel] = num;
    mask_d = mask_wr ? en_mask : mask_q;
  end

  always_comb begin
    anode_d   = '1;
    cathode_d = SegOff;
    if (state_q == StShow && mask_q[idx_q]) begin
      anode_d   = ~(AnodeOne << idx_q);
      cathode_d = hex_to_seg(digit_q[idx_q]);
    end
    tick_d = slot_end && (idx_q == IdxLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StBlank;
      cnt_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      mask_q    <= '1;
      anode_q   <= '1;
      cathode_q <= SegOff;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      mask_q    <= mask_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      tick_q    <= tick_d;
    end
  end

  assign ANODE      = anode_q;
  assign CATHODE    = cathode_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_sevenseg_scan_ctrl;

  localparam int unsigned Div = 8;
  localparam int unsigned Blank = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [2:0] sel = '0;
  logic [3:0] num = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] en_mask = 8'hFF;
  logic [7:0] ANODE;
  logic [6:0] CATHODE;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  int edges = 0;
  logic [3:0] dig_m [8];
  logic [7:0] mask_m = 8'hFF;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (Div),
    .BLANK_CYCLES(Blank)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .sel       (sel),
    .num       (num),
    .mask_wr   (mask_wr),
    .en_mask   (en_mask),
    .ANODE     (ANODE),
    .CATHODE   (CATHODE),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Output after edge e reflects the counter state left by edge e-1.
  function automatic logic [7:0] exp_anode(input int e);
    int p = e - 1;
    int s = (p / 8) % 8;
    int c = p % 8;
    if (c >= int'(Blank) && mask_m[s]) return ~(8'd1 << s);
    return 8'hFF;
  endfunction

  function automatic logic [6:0] exp_cathode(input int e);
    int p = e - 1;
    int s = (p / 8) % 8;
    int c = p % 8;
    if (c >= int'(Blank) && mask_m[s]) return seg(dig_m[s]);
    return 7'h7F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) dig_m[i] = 4'h0;
    mask_m = 8'hFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL rst_anode: got %h want ff", ANODE); end
    total++; if (CATHODE !== 7'h7F) begin bad++; $display("FAIL rst_cathode: got %h want 7f", CATHODE); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    edges = 0;
    model_clear();
    step();
    total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL rel_e1_anode: got %h want ff", ANODE); end
    step();
    total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL rel_e2_anode: got %h want ff", ANODE); end
    step();
    total++; if (ANODE !== 8'hFE) begin bad++; $display("FAIL rel_e3_anode: got %h want fe", ANODE); end
    total++; if (CATHODE !== 7'h40) begin bad++; $display("FAIL rel_e3_cathode: got %h want 40", CATHODE); end
  endtask

  task automatic test_scan();
    for (int k = 0; k < 8; k++) begin
      write = 1'b1; sel = 3'(k); num = 4'(k);
      step();
    end
    write = 1'b0;
    for (int k = 0; k < 8; k++) dig_m[k] = 4'(k);
    while (edges < 64) begin
      step();
      total++; if (ANODE !== exp_anode(edges)) begin
        bad++; $display("FAIL scan_anode e=%0d: got %h want %h", edges, ANODE, exp_anode(edges));
      end
      total++; if (CATHODE !== exp_cathode(edges)) begin
        bad++; $display("FAIL scan_cathode e=%0d: got %h want %h", edges, CATHODE, exp_cathode(edges));
      end
      total++; if (frame_tick !== (edges % 64 == 0)) begin
        bad++; $display("FAIL scan_tick e=%0d: got %b", edges, frame_tick);
      end
      if (edges == 30) begin
        total++; if (CATHODE !== 7'h30 || ANODE !== 8'hF7) begin
          bad++; $display("FAIL slot3: got %h/%h want f7/30", ANODE, CATHODE);
        end
      end
      if (edges == 62) begin
        total++; if (CATHODE !== 7'h78 || ANODE !== 8'h7F) begin
          bad++; $display("FAIL slot7: got %h/%h want 7f/78", ANODE, CATHODE);
        end
      end
    end
  endtask

  task automatic test_frame_tick();
    int ticks = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        ticks++;
        total++; if (edges % 64 != 0) begin bad++; $display("FAIL tick_pos: got e=%0d want mod64=0", edges); end
      end
    end
    total++; if (ticks != 1) begin bad++; $display("FAIL tick_count: got %0d want 1", ticks); end
  endtask

  task automatic test_blanking();
    int run = 0;
    int bounds = 0;
    while (edges % 8 != 0) step();
    for (int i = 0; i < 192; i++) begin
      step();
      total++; if ($countones(~ANODE) > 1) begin bad++; $display("FAIL anode_onehot: got %h", ANODE); end
      total++; if (ANODE !== exp_anode(edges)) begin
        bad++; $display("FAIL blank_anode e=%0d: got %h want %h", edges, ANODE, exp_anode(edges));
      end
      if (ANODE === 8'hFF) run++;
      else if (run != 0) begin
        bounds++;
        total++; if (run != 2) begin bad++; $display("FAIL blank_len: got %0d want 2", run); end
        run = 0;
      end
    end
    total++; if (bounds != 24) begin bad++; $display("FAIL blank_bounds: got %0d want 24", bounds); end
  endtask

  task automatic test_mask();
    int lit_lo = 0;
    int lit_hi = 0;
    mask_wr = 1'b1; en_mask = 8'h0F;
    step();
    mask_wr = 1'b0; en_mask = 8'hFF;
    mask_m = 8'h0F;
    for (int i = 0; i < 64; i++) begin
      step();
      total++; if (ANODE !== exp_anode(edges)) begin
        bad++; $display("FAIL mask_anode e=%0d: got %h want %h", edges, ANODE, exp_anode(edges));
      end
      if (ANODE[3:0] !== 4'hF) lit_lo++;
      if (ANODE[7:4] !== 4'hF) lit_hi++;
    end
    total++; if (lit_hi != 0) begin bad++; $display("FAIL mask_dark: got %0d want 0", lit_hi); end
    total++; if (lit_lo != 24) begin bad++; $display("FAIL mask_lit: got %0d want 24", lit_lo); end
    mask_wr = 1'b1;
    step();
    mask_wr = 1'b0;
    mask_m = 8'hFF;
  endtask

  task automatic test_write_during_show();
    while (edges % 64 != 20) step();
    total++; if (ANODE !== 8'hFB || CATHODE !== 7'h24) begin
      bad++; $display("FAIL wshow_pre: got %h/%h want fb/24", ANODE, CATHODE);
    end
    write = 1'b1; sel = 3'd2; num = 4'hF;
    step();
    write = 1'b0;
    total++; if (ANODE !== 8'hFB || CATHODE !== 7'h24) begin
      bad++; $display("FAIL wshow_edge: got %h/%h want fb/24", ANODE, CATHODE);
    end
    step();
    total++; if (ANODE !== 8'hFB || CATHODE !== 7'h0E) begin
      bad++; $display("FAIL wshow_post: got %h/%h want fb/0e", ANODE, CATHODE);
    end
    dig_m[2] = 4'hF;
  endtask

  task automatic test_back_to_back();
    while (edges % 64 != 0) step();
    write = 1'b1; sel = 3'd2; num = 4'hA;
    mask_wr = 1'b1; en_mask = 8'hF7;
    step();
    num = 4'h5; mask_wr = 1'b0; en_mask = 8'hFF;
    step();
    write = 1'b0;
    dig_m[2] = 4'h5;
    mask_m = 8'hF7;
    for (int i = 0; i < 64; i++) begin
      step();
      total++; if (ANODE !== exp_anode(edges) || CATHODE !== exp_cathode(edges)) begin
        bad++; $display("FAIL b2b_out e=%0d: got %h/%h want %h/%h", edges, ANODE, CATHODE,
                        exp_anode(edges), exp_cathode(edges));
      end
      if (edges % 64 == 21) begin
        total++; if (CATHODE !== 7'h12) begin bad++; $display("FAIL b2b_last: got %h want 12", CATHODE); end
      end
      if (edges % 64 == 29) begin
        total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL b2b_mask: got %h want ff", ANODE); end
      end
    end
    mask_wr = 1'b1;
    step();
    mask_wr = 1'b0;
    mask_m = 8'hFF;
  endtask

  task automatic test_reset_mid_show();
    while (edges % 64 != 45) step();
    total++; if (ANODE !== 8'hDF || CATHODE !== 7'h12) begin
      bad++; $display("FAIL mid_pre: got %h/%h want df/12", ANODE, CATHODE);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL mid_rst_anode: got %h want ff", ANODE); end
    total++; if (CATHODE !== 7'h7F) begin bad++; $display("FAIL mid_rst_cathode: got %h want 7f", CATHODE); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    edges = 0;
    model_clear();
    step();
    step();
    total++; if (ANODE !== 8'hFF) begin bad++; $display("FAIL mid_rel_e2: got %h want ff", ANODE); end
    step();
    total++; if (ANODE !== 8'hFE || CATHODE !== 7'h40) begin
      bad++; $display("FAIL mid_rel_e3: got %h/%h want fe/40", ANODE, CATHODE);
    end
    while (edges < 12) step();
    total++; if (ANODE !== 8'hFD || CATHODE !== 7'h40) begin
      bad++; $display("FAIL mid_rel_slot1: got %h/%h want fd/40", ANODE, CATHODE);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_tick();
    test_blanking();
    test_mask();
    test_write_during_show();
    test_back_to_back();
    test_reset_mid_show();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
